// File: rtl/multiply_delta_seq.sv
// Output-layer delta stage: delta = |add_val| * out_exp / SCALE per channel, one shared multiplier
// and a bit-serial restoring divider. Define DELTA_ROUND_EN to round to nearest instead of truncating.
module multiply_delta_seq #(
  parameter int CH    = 5,
  parameter int W     = 10,
  parameter int SCALE = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CH*W-1:0] add_val,
  input  logic [CH*W-1:0] out_exp,
  output logic            busy,
  output logic            done,
  output logic [CH-1:0]   sign_o,
  output logic [CH*W-1:0] delta_o
);

  localparam int DW  = 2 * W;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW  = $clog2(DW);
  localparam logic [DW:0]    SCALE_V  = (DW + 1)'(SCALE);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CH - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
`ifdef DELTA_ROUND_EN
  localparam logic [DW:0]    HALF_V   = (DW + 1)'(SCALE / 2);
`endif

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_WR, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [W-1:0]    add_in  [CH];
  logic [W-1:0]    exp_in  [CH];
  logic [W-1:0]    add_reg [CH];
  logic [W-1:0]    exp_reg [CH];
  logic [CHW-1:0]  ch_reg;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   dvd_reg;
  logic [DW-1:0]   rem_reg;
  logic [DW-1:0]   quo_reg;
  logic [CH*W-1:0] shadow_delta_reg;
  logic [CH-1:0]   shadow_sign_reg;

  logic [W-1:0]    cur_add, cur_exp, abs_val, quo_sat;
  logic [DW-1:0]   prod, rem_next;
  logic [DW:0]     dvd_full, trial, rem_step;
  logic            q_bit;
  logic [CH*W-1:0] shadow_next;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_unpack
      assign add_in[gi] = add_val[gi*W +: W];
      assign exp_in[gi] = out_exp[gi*W +: W];
    end
  endgenerate

  assign cur_add = add_reg[ch_reg];
  assign cur_exp = exp_reg[ch_reg];
  // Two's-complement negate in W bits; the most negative value maps to 2^(W-1) as unsigned.
  assign abs_val = cur_add[W-1] ? (W'(0) - cur_add) : cur_add;
  assign prod    = DW'(abs_val) * DW'(cur_exp);
`ifdef DELTA_ROUND_EN
  assign dvd_full = {1'b0, prod} + HALF_V;
`else
  assign dvd_full = {1'b0, prod};
`endif

  // Remainder stays below SCALE, so the shifted trial value always fits in DW+1 bits.
  assign trial    = {rem_reg, dvd_reg[DW-1]};
  assign q_bit    = (trial >= SCALE_V);
  assign rem_step = q_bit ? (trial - SCALE_V) : trial;
  assign rem_next = rem_step[DW-1:0];
  assign quo_sat  = (|quo_reg[DW-1:W]) ? {W{1'b1}} : quo_reg[W-1:0];

  always_comb begin
    shadow_next = shadow_delta_reg;
    shadow_next[ch_reg*W +: W] = quo_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_MUL;
      S_MUL:  state_next = S_DIV;
      S_DIV:  if (cnt_reg == CNT_LAST) state_next = S_WR;
      S_WR:   state_next = (ch_reg == CH_LAST) ? S_DONE : S_MUL;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        add_reg[i] <= '0;
        exp_reg[i] <= '0;
      end
      ch_reg           <= '0;
      cnt_reg          <= '0;
      dvd_reg          <= '0;
      rem_reg          <= '0;
      quo_reg          <= '0;
      shadow_delta_reg <= '0;
      shadow_sign_reg  <= '0;
      delta_o          <= '0;
      sign_o           <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < CH; i++) begin
              add_reg[i] <= add_in[i];
              exp_reg[i] <= exp_in[i];
            end
            ch_reg <= '0;
          end
        end
        S_MUL: begin
          // The extra rounding bit seeds the remainder so DIV still takes DW cycles.
          dvd_reg <= dvd_full[DW-1:0];
          rem_reg <= {{(DW-1){1'b0}}, dvd_full[DW]};
          quo_reg <= '0;
          cnt_reg <= '0;
          shadow_sign_reg[ch_reg] <= cur_add[W-1];
        end
        S_DIV: begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[DW-2:0], q_bit};
          dvd_reg <= {dvd_reg[DW-2:0], 1'b0};
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_WR: begin
          shadow_delta_reg <= shadow_next;
          if (ch_reg == CH_LAST) begin
            delta_o <= shadow_next;
            sign_o  <= shadow_sign_reg;
          end else begin
            ch_reg <= ch_reg + CHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_delta_seq.sv
// Directed self-checking bench for multiply_delta_seq: table-driven runs plus reset, handshake,
// abort and saturation sequences. Expected values follow DELTA_ROUND_EN when it is defined.
module tb_multiply_delta_seq;
  localparam int CH = 5;
  localparam int W  = 10;
  localparam int N  = CH * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  add_val = '0;
  logic [N-1:0]  out_exp = '0;
  logic          busy, done;
  logic [CH-1:0] sign_o;
  logic [N-1:0]  delta_o;

  logic          start_s = 1'b0;
  logic [N-1:0]  add_s = '0;
  logic [N-1:0]  exp_s = '0;
  logic          busy_s, done_s;
  logic [CH-1:0] sign_s;
  logic [N-1:0]  delta_s;

  int checks = 0;
  int failures = 0;

  multiply_delta_seq #(.CH(CH), .W(W), .SCALE(1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .add_val(add_val), .out_exp(out_exp),
    .busy(busy), .done(done), .sign_o(sign_o), .delta_o(delta_o)
  );

  multiply_delta_seq #(.CH(CH), .W(W), .SCALE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .add_val(add_s), .out_exp(exp_s),
    .busy(busy_s), .done(done_s), .sign_o(sign_s), .delta_o(delta_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [N-1:0]  av;
    logic [N-1:0]  ev;
    logic [N-1:0]  dl;
    logic [CH-1:0] sg;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Launch one run, optionally inject ignored start pulses, and check timing plus results.
  task automatic run_vec(input vec_t v, input bit inject);
    int first;
    int pulses;
    logic busy_at, busy_after, busy_end;
    first = 0;
    pulses = 0;
    busy_at = 1'b0;
    busy_after = 1'b1;
    busy_end = 1'b1;
    @(negedge clk);
    add_val = v.av;
    out_exp = v.ev;
    start = 1'b1;
    for (int cyc = 1; cyc <= 130; cyc++) begin
      @(negedge clk);
      start = inject && (cyc == 5 || cyc == 110 || cyc == 111);
      add_val = ~v.av;
      out_exp = ~v.ev;
      if (done) begin
        pulses++;
        if (first == 0) first = cyc;
      end
      if (cyc == 111) busy_at = busy;
      if (cyc == 112) busy_after = busy;
      if (cyc == 130) busy_end = busy;
    end
    start = 1'b0;
    $display("run %s: done_cycle=%0d pulses=%0d delta_o=%h sign_o=%b", v.name, first, pulses, delta_o, sign_o);
    chk({v.name, "_done_cycle"}, 64'(first), 64'd111);
    chk({v.name, "_done_pulses"}, 64'(pulses), 64'd1);
    chk({v.name, "_delta"}, 64'(delta_o), 64'(v.dl));
    chk({v.name, "_sign"}, 64'(sign_o), 64'(v.sg));
    chk({v.name, "_busy_at_done"}, 64'(busy_at), 64'd1);
    chk({v.name, "_busy_after_done"}, 64'(busy_after), 64'd0);
    chk({v.name, "_busy_end"}, 64'(busy_end), 64'd0);
  endtask

  initial begin
    logic changed;
    int first_s;

    tbl[0].name = "mixed";
    tbl[0].av = {10'd300, -10'sd300, -10'sd512, 10'd0, 10'd511};
    tbl[0].ev = {10'd1000, 10'd500, 10'd1023, 10'd1023, 10'd1};
    tbl[0].sg = 5'b01100;
    tbl[1].name = "ones";
    tbl[1].av = {5{10'd1}};
    tbl[1].ev = {5{10'd1000}};
    tbl[1].dl = {5{10'd1}};
    tbl[1].sg = 5'b00000;
    tbl[2].name = "neg_small";
    tbl[2].av = {5{10'h3FF}};
    tbl[2].ev = {5{10'd999}};
    tbl[2].sg = 5'b11111;
    tbl[3].name = "assorted";
    tbl[3].av = {10'd499, -10'sd256, 10'd255, -10'sd7, 10'd100};
    tbl[3].ev = {10'd1, 10'd4, 10'd1023, 10'd1000, 10'd15};
    tbl[3].sg = 5'b01010;
`ifdef DELTA_ROUND_EN
    tbl[0].dl = {10'd300, 10'd150, 10'd524, 10'd0, 10'd1};
    tbl[2].dl = {5{10'd1}};
    tbl[3].dl = {10'd0, 10'd1, 10'd261, 10'd7, 10'd2};
`else
    tbl[0].dl = {10'd300, 10'd150, 10'd523, 10'd0, 10'd0};
    tbl[2].dl = {5{10'd0}};
    tbl[3].dl = {10'd0, 10'd1, 10'd260, 10'd7, 10'd1};
`endif

    // Reset state, then idle hold with start low.
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sign", 64'(sign_o), 64'd0);
    chk("rst_delta", 64'(delta_o), 64'd0);
    rst_n = 1'b1;
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || sign_o !== '0 || delta_o !== '0) changed = 1'b1;
    end
    $display("idle hold: changed=%0b", changed);
    chk("idle_hold", 64'(changed), 64'd0);

    // Back-to-back runs; run 1 also carries ignored start pulses mid-run and in DONE.
    for (int i = 0; i < 4; i++) run_vec(tbl[i], i == 1);

    // Abort during channel 2's divide phase (channel 2 DIV spans cycles 46..65).
    @(negedge clk);
    add_val = tbl[0].av;
    out_exp = tbl[0].ev;
    start = 1'b1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    $display("abort: busy=%0b done=%0b delta_o=%h sign_o=%b", busy, done, delta_o, sign_o);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_delta", 64'(delta_o), 64'd0);
    chk("abort_sign", 64'(sign_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(tbl[0], 1'b0);

    // Saturation instance: SCALE=1, every quotient exceeds 2^W-1.
    @(negedge clk);
    add_s = {5{10'd511}};
    exp_s = {5{10'd1023}};
    start_s = 1'b1;
    first_s = 0;
    for (int cyc = 1; cyc <= 130; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (done_s && first_s == 0) first_s = cyc;
    end
    $display("run saturate: done_cycle=%0d delta_o=%h sign_o=%b", first_s, delta_s, sign_s);
    chk("sat_done_cycle", 64'(first_s), 64'd111);
    chk("sat_delta", 64'(delta_s), 64'({5{10'd1023}}));
    chk("sat_sign", 64'(sign_s), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
